// File: rtl/trace_uart_if.sv
// Trace-port to UART-printer bundle: cpu trace input plus printer status outputs.
interface trace_uart_if;
  logic        trace_valid;
  logic [35:0] trace_data;
  logic        serialOut;
  logic        fifo_full;
  logic        overflow;
  logic [15:0] dropped_count;
  logic        busy;

  modport master (output trace_valid, trace_data,
                  input  serialOut, fifo_full, overflow, dropped_count, busy);
  modport slave  (input  trace_valid, trace_data,
                  output serialOut, fifo_full, overflow, dropped_count, busy);
endinterface

// File: rtl/trace_uart.sv
// Buffers 36-bit cpu trace words and prints each as 9 hex digits + CR LF on an 8N1 UART.
module trace_uart #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic         clk,
  input  logic         reset,
  trace_uart_if.slave  tif
);
  localparam int DIVISOR = CLK_HZ / BAUD;
  localparam int DIV_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  logic [35:0]        mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               fifo_full_q, fifo_full_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        dropped_q, dropped_d;
  state_t             state_q, state_d;
  logic [35:0]        word_q, word_d;
  logic [3:0]         char_idx_q, char_idx_d;
  logic [8:0]         shreg_q, shreg_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               ser_q, ser_d;
  logic               wr, rd;

  function automatic logic [7:0] glyph(input logic [35:0] w, input logic [3:0] idx);
    logic [35:0] sh;
    logic [3:0]  n;
    sh = w << {idx, 2'b00};
    n  = sh[35:32];
    if (idx == 4'd9)       glyph = 8'h0D;
    else if (idx == 4'd10) glyph = 8'h0A;
    else if (n < 4'd10)    glyph = 8'h30 + {4'h0, n};
    else                   glyph = 8'h37 + {4'h0, n};
  endfunction

  assign wr = tif.trace_valid & ~fifo_full_q;
  assign rd = (state_q == IDLE) & (count_q != '0);

  always_comb begin
    wr_ptr_d    = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q + (FIFO_AW+1)'(wr) - (FIFO_AW+1)'(rd);
    fifo_full_d = (count_d == (FIFO_AW+1)'(FIFO_DEPTH));
    overflow_d  = overflow_q;
    dropped_d   = dropped_q;
    if (tif.trace_valid && fifo_full_q) begin
      overflow_d = 1'b1;
      if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
    end

    state_d    = state_q;
    word_d     = word_q;
    char_idx_d = char_idx_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    ser_d      = ser_q;
    case (state_q)
      IDLE: if (rd) begin
        word_d     = mem[rd_ptr_q];
        char_idx_d = 4'd0;
        state_d    = LOAD;
      end
      LOAD: begin
        ser_d     = 1'b0;
        shreg_d   = {1'b1, glyph(word_q, char_idx_q)};
        bit_cnt_d = 4'd0;
        div_cnt_d = '0;
        state_d   = SEND;
      end
      default: begin
        if (div_cnt_q == DIV_W'(DIVISOR - 1)) begin
          div_cnt_d = '0;
          if (bit_cnt_q != 4'd9) begin
            ser_d     = shreg_q[0];
            shreg_d   = {1'b1, shreg_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (char_idx_q == 4'd10) begin
            state_d = IDLE;
          end else begin
            // Next char's start bit begins on this same edge so chars of a word abut.
            char_idx_d = char_idx_q + 4'd1;
            ser_d      = 1'b0;
            shreg_d    = {1'b1, glyph(word_q, char_idx_q + 4'd1)};
            bit_cnt_d  = 4'd0;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= tif.trace_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_full_q <= 1'b0;
      overflow_q  <= 1'b0;
      dropped_q   <= '0;
      state_q     <= IDLE;
      word_q      <= '0;
      char_idx_q  <= '0;
      shreg_q     <= '1;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      ser_q       <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_full_q <= fifo_full_d;
      overflow_q  <= overflow_d;
      dropped_q   <= dropped_d;
      state_q     <= state_d;
      word_q      <= word_d;
      char_idx_q  <= char_idx_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      ser_q       <= ser_d;
    end
  end

  assign tif.serialOut     = ser_q;
  assign tif.fifo_full     = fifo_full_q;
  assign tif.overflow      = overflow_q;
  assign tif.dropped_count = dropped_q;
  assign tif.busy          = (state_q != IDLE) | (count_q != '0);
endmodule
